// File: rtl/seq_test_pkg.sv
// Shared types and constants for the detector test sequencer and its display path.
// Segment codes are active-high, bit order gfedcba.
package seq_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    REPORT
  } seq_state_t;

  // Serial level presented to the detector whenever no test bit is being shifted.
  localparam logic IDLE_BIT = 1'b1;

  localparam logic [6:0] SEG_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble, input logic blank);
    seg_encode = blank ? SEG_BLANK : SEG_CODE[nibble];
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// DEPTH-deep 1-bit shift register with synchronous clear; aligns "in-window"
// tags with the detector's output latency.
module tag_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic tag_in,
  output logic tag_out
);

  logic [DEPTH-1:0] line;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (clr) line <= '0;
        else     line <= tag_in;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (clr) line <= '0;
        else     line <= {line[DEPTH-2:0], tag_in};
      end
    end
  endgenerate

  assign tag_out = line[DEPTH-1];

endmodule

// File: rtl/detector_test_sequencer.sv
// Feeds one parallel test word MSB-first into the 01[0*]1 detector and counts
// detector matches that belong to that word's shift window.
//
// state  | meaning
// IDLE   | waiting for a test word, in_ready high
// CLEAR  | one cycle of detector reset before shifting
// SHIFT  | one word bit per cycle, detector enabled
// DRAIN  | DET_LATENCY cycles for the last bit's match to arrive
// REPORT | result held until the consumer takes it
module detector_test_sequencer
  import seq_test_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int LEN_W       = 5,
  parameter int CNT_W       = 8,
  parameter int DET_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] word_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic              det_sig,
  output logic              det_ena,
  output logic              det_rst,
  input  logic              det_z,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_sat,
  output logic [15:0]       total_count,
  output logic              busy
);

  localparam int TMR_W = (LEN_W > $clog2(DET_LATENCY + 1)) ? LEN_W : $clog2(DET_LATENCY + 1);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(WORD_W);
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DET_LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  seq_state_t state, state_nxt;

  logic [WORD_W-1:0] word_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_clamped;
  logic [TMR_W-1:0]  tmr_q;
  logic              tmr_tc;
  logic              accept;
  logic              release_res;
  logic              tag_in;
  logic              tag_out;
  logic              hit;
  logic [16:0]       total_sum;

  assign accept      = in_ready & in_valid;
  assign release_res = res_valid & res_ready;
  assign tmr_tc      = (tmr_q == TMR_W'(1));
  assign tag_in      = (state == SHIFT);
  assign hit         = tag_out & det_z;
  assign len_clamped = (len_in > LEN_MAX) ? LEN_MAX : len_in;
  assign total_sum   = {1'b0, total_count} + 17'(res_count);

  tag_delay_line #(
    .DEPTH(DET_LATENCY)
  ) u_tag_delay (
    .clk    (clk),
    .clr    (rst | (state == CLEAR)),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = CLEAR;
      CLEAR:   state_nxt = (len_q != '0) ? SHIFT : DRAIN;
      SHIFT:   if (tmr_tc) state_nxt = DRAIN;
      DRAIN:   if (tmr_tc) state_nxt = REPORT;
      REPORT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset overrides every handshake and detector control combinationally.
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    det_ena   = 1'b0;
    det_sig   = IDLE_BIT;
    det_rst   = 1'b0;
    busy      = 1'b0;
    if (rst) begin
      det_rst = 1'b1;
    end else begin
      busy = (state != IDLE);
      unique case (state)
        IDLE:   in_ready = 1'b1;
        CLEAR:  det_rst = 1'b1;
        SHIFT: begin
          det_ena = 1'b1;
          det_sig = word_q[WORD_W-1];
        end
        REPORT: res_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // The word is left-aligned on accept so the next bit is always the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q      <= '0;
      len_q       <= '0;
      tmr_q       <= '0;
      res_count   <= '0;
      res_sat     <= 1'b0;
      total_count <= '0;
    end else begin
      if (accept) begin
        word_q <= word_in << (LEN_MAX - len_clamped);
        len_q  <= len_clamped;
      end else if (state == SHIFT) begin
        word_q <= word_q << 1;
      end

      unique case (state)
        CLEAR:   tmr_q <= (len_q != '0) ? TMR_W'(len_q) : DRAIN_LOAD;
        SHIFT:   tmr_q <= tmr_tc ? DRAIN_LOAD : tmr_q - TMR_W'(1);
        DRAIN:   tmr_q <= tmr_q - TMR_W'(1);
        default: tmr_q <= tmr_q;
      endcase

      if (accept) begin
        res_count <= '0;
        res_sat   <= 1'b0;
      end else if (hit) begin
        if (res_count == CNT_MAX) res_sat <= 1'b1;
        else                      res_count <= res_count + CNT_W'(1);
      end

      if (release_res)
        total_count <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
  end

endmodule

// File: tb/tb_detector_test_sequencer.sv
// Directed bench: two sequencers (CNT_W=8 and CNT_W=2) each driving a
// behavioural 01[0*]1 detector with one cycle of latency.
module tb_detector_test_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid  = 1'b0;
  logic        res_ready = 1'b0;
  logic        z_inject  = 1'b0;
  logic [15:0] word_in   = '0;
  logic [4:0]  len_in    = '0;

  logic [1:0] in_ready, det_sig, det_ena, det_rst, res_valid, res_sat, busy, det_z;
  logic [7:0]  res_count0;
  logic [1:0]  res_count1;
  logic [15:0] total0, total1;

  // Detector model: a 1 matches when the previous 1 was immediately preceded by a 0.
  logic [1:0] m_last, m_armed, m_z;
  assign det_z = m_z | {2{z_inject}};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (det_rst[k]) begin
        m_last[k]  <= 1'b1;
        m_armed[k] <= 1'b0;
        m_z[k]     <= 1'b0;
      end else if (det_ena[k]) begin
        m_z[k] <= det_sig[k] & m_armed[k];
        if (det_sig[k]) m_armed[k] <= ~m_last[k];
        m_last[k] <= det_sig[k];
      end else begin
        m_z[k] <= 1'b0;
      end
    end
  end

  detector_test_sequencer #(
    .WORD_W(16), .LEN_W(5), .CNT_W(8), .DET_LATENCY(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .word_in(word_in), .len_in(len_in), .det_sig(det_sig[0]), .det_ena(det_ena[0]),
    .det_rst(det_rst[0]), .det_z(det_z[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready), .res_count(res_count0), .res_sat(res_sat[0]),
    .total_count(total0), .busy(busy[0])
  );

  detector_test_sequencer #(
    .WORD_W(16), .LEN_W(5), .CNT_W(2), .DET_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .word_in(word_in), .len_in(len_in), .det_sig(det_sig[1]), .det_ena(det_ena[1]),
    .det_rst(det_rst[1]), .det_z(det_z[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready), .res_count(res_count1), .res_sat(res_sat[1]),
    .total_count(total1), .busy(busy[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a word, wait for acceptance, then run until res_valid (sampled at negedge).
  task automatic send_word(input logic [15:0] w, input logic [4:0] l,
                           output int lat, output int n_ena, output int n_rst, output int rst_pos);
    bit got;
    lat = 0; n_ena = 0; n_rst = 0; rst_pos = 0;
    word_in = w; len_in = l; in_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (in_ready[0]) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) check("accept_timeout", {31'd0, in_ready[0]}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 100 && lat == 0; c++) begin
      @(negedge clk);
      if (det_ena[0]) n_ena++;
      if (det_rst[0]) begin n_rst++; rst_pos = c; end
      if (res_valid[0]) lat = c;
      else begin @(posedge clk); #1; end
    end
    if (lat == 0) check("result_timeout", {31'd0, res_valid[0]}, 32'd1);
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic run_word(input string name, input logic [15:0] w, input logic [4:0] l, input int exp_cnt);
    int lat, n_ena, n_rst, rst_pos;
    send_word(w, l, lat, n_ena, n_rst, rst_pos);
    check({name, "_count"}, 32'(res_count0), 32'(exp_cnt));
    take_result();
    exp_total += exp_cnt;
    check({name, "_total"}, 32'(total0), 32'(exp_total));
  endtask

  typedef struct {
    logic [15:0] word;
    logic [4:0]  len;
    int          exp_cnt;
    logic        exp_sat;
    logic        chk1;
    int          exp_cnt1;
    logic        exp_sat1;
    int          exp_lat;
    int          exp_shift;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, n_ena, n_rst, rst_pos;
    bit stable;

    vecs[0] = '{16'h004B,  5'd8, 3, 1'b0, 1'b0, 0, 1'b0, 11,  8};
    vecs[1] = '{16'hFFFF, 5'd16, 0, 1'b0, 1'b0, 0, 1'b0, 19, 16};
    vecs[2] = '{16'h1234,  5'd0, 0, 1'b0, 1'b0, 0, 1'b0,  3,  0};
    vecs[3] = '{16'h5555, 5'd16, 7, 1'b0, 1'b1, 3, 1'b1, 19, 16};
    vecs[4] = '{16'h5555, 5'd20, 7, 1'b0, 1'b1, 3, 1'b1, 19, 16};
    vecs[5] = '{16'hFF05,  5'd4, 1, 1'b0, 1'b0, 0, 1'b0,  7,  4};
    vecs[6] = '{16'h0009,  5'd5, 1, 1'b0, 1'b0, 0, 1'b0,  8,  5};
    vecs[7] = '{16'h0001,  5'd1, 0, 1'b0, 1'b0, 0, 1'b0,  4,  1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready[0]},  32'd0);
    check("rst_res_valid", {31'd0, res_valid[0]}, 32'd0);
    check("rst_det_rst",   {31'd0, det_rst[0]},   32'd1);
    check("rst_det_sig",   {31'd0, det_sig[0]},   32'd1);
    check("rst_det_ena",   {31'd0, det_ena[0]},   32'd0);
    check("rst_busy",      {31'd0, busy[0]},      32'd0);
    check("rst_count",     32'(res_count0),       32'd0);
    check("rst_total",     32'(total0),           32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready[0]}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      send_word(vecs[i].word, vecs[i].len, lat, n_ena, n_rst, rst_pos);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_shift_cycles", i), 32'(n_ena), 32'(vecs[i].exp_shift));
      check($sformatf("v%0d_det_rst_cycles", i), 32'(n_rst), 32'd1);
      check($sformatf("v%0d_det_rst_pos", i), 32'(rst_pos), 32'd1);
      check($sformatf("v%0d_count", i), 32'(res_count0), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_sat", i), {31'd0, res_sat[0]}, {31'd0, vecs[i].exp_sat});
      check($sformatf("v%0d_busy", i), {31'd0, busy[0]}, 32'd1);
      if (vecs[i].chk1) begin
        check($sformatf("v%0d_count_w2", i), 32'(res_count1), 32'(vecs[i].exp_cnt1));
        check($sformatf("v%0d_sat_w2", i), {31'd0, res_sat[1]}, {31'd0, vecs[i].exp_sat1});
      end
      take_result();
      exp_total += vecs[i].exp_cnt;
      check($sformatf("v%0d_total", i), 32'(total0), 32'(exp_total));
    end

    // Backpressure: result held, stray det_z and a pending word must be ignored.
    send_word(16'h004B, 5'd8, lat, n_ena, n_rst, rst_pos);
    check("bp_count", 32'(res_count0), 32'd3);
    word_in = 16'hFFFF; len_in = 5'd16; in_valid = 1'b1; z_inject = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!(res_valid[0] && res_count0 == 8'd3 && !in_ready[0] && busy[0])) stable = 1'b0;
    end
    z_inject = 1'b0;
    check("bp_stable", {31'd0, stable}, 32'd1);
    take_result();
    exp_total += 3;
    @(negedge clk);
    check("bp_ready_after", {31'd0, in_ready[0]}, 32'd1);
    check("bp_total", 32'(total0), 32'(exp_total));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_accepted", {31'd0, busy[0]}, 32'd1);
    lat = 0;
    for (int c = 0; c < 100 && lat == 0; c++) begin
      @(negedge clk);
      if (res_valid[0]) lat = 1;
      else begin @(posedge clk); #1; end
    end
    check("bp_next_done", {31'd0, res_valid[0]}, 32'd1);
    check("bp_next_count", 32'(res_count0), 32'd0);
    take_result();

    // Reset in the middle of SHIFT (idx 4).
    word_in = 16'hFFFF; len_in = 5'd16; in_valid = 1'b1;
    @(negedge clk);
    check("mr_accept", {31'd0, in_ready[0]}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    check("mr_in_shift", {31'd0, det_ena[0]}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mr_det_rst",  {31'd0, det_rst[0]},  32'd1);
    check("mr_det_ena",  {31'd0, det_ena[0]},  32'd0);
    check("mr_det_sig",  {31'd0, det_sig[0]},  32'd1);
    check("mr_in_ready", {31'd0, in_ready[0]}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mr_busy",      {31'd0, busy[0]},      32'd0);
    check("mr_res_valid", {31'd0, res_valid[0]}, 32'd0);
    check("mr_total",     32'(total0),           32'd0);
    check("mr_count",     32'(res_count0),       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_idle_ready", {31'd0, in_ready[0]}, 32'd1);
    @(posedge clk); #1;

    exp_total = 0;
    run_word("rt_a", 16'h004B, 5'd8, 3);
    run_word("rt_b", 16'hFFFF, 5'd16, 0);
    run_word("rt_c", 16'h5555, 5'd16, 7);
    check("rt_final_total", 32'(total0), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
